// File: rtl/clk_sched_pkg.sv
// Shared state encodings, phase-decode constants and helpers for the clock scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // Last phase value of each strobe period; all three line up at 31.
    localparam logic [2:0] PH_4F_LAST = 3'd7;
    localparam logic [3:0] PH_2F_LAST = 4'd15;
    localparam logic [4:0] PH_F_LAST  = 5'd31;

    // Lane index of a one-hot grant vector (0 when the vector is empty).
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/clk_sched_ctrl_rr_arb4.sv
// Four-lane round-robin selector: first set request at or after (ptr + 1) mod 4.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample gnt/found.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       found
);

    logic [1:0] idx;

    // Scan from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        gnt   = 4'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'd1 + 2'(i);
            if (req[idx]) begin
                gnt   = 4'b0001 << idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_sched_ctrl.sv
// Scheduler: f/2f/4f phase strobes, SYNC warm-up, then round-robin lane grants per 4f slot.
// Latency: grant updates one edge after the en_4f slot cycle and holds for 8 cycles.
// Backpressure: none; lane_valid is only sampled on en_4f slot cycles.
module clk_sched_ctrl
    import clk_sched_pkg::*;
#(
    parameter int SYNC_PERIODS = 4
) (
    input  logic       clk32f,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] lane_valid,
    output logic       en_4f,
    output logic       en_2f,
    output logic       en_f,
    output logic       sync_active,
    output logic [3:0] grant,
    output logic       grant_vld,
    output logic [1:0] state_o
);

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_PERIODS);

    state_e     state_q, state_d;
    logic [4:0] cnt_q,   cnt_d;
    logic [3:0] per_q,   per_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] grant_q, grant_d;

    logic [3:0] arb_gnt;
    logic       arb_found;
    logic       run;

    rr_arb4 u_arb (
        .req   (lane_valid),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .found (arb_found)
    );

    // Every output is a decode of flops only.
    assign run         = (state_q != ST_IDLE);
    assign en_4f       = run && (cnt_q[2:0] == PH_4F_LAST);
    assign en_2f       = run && (cnt_q[3:0] == PH_2F_LAST);
    assign en_f        = run && (cnt_q      == PH_F_LAST);
    assign sync_active = (state_q == ST_SYNC);
    assign grant       = grant_q;
    assign grant_vld   = |grant_q;
    assign state_o     = state_q;

    // Next-state, phase, period, pointer and grant logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = run ? cnt_q + 5'd1 : 5'd0;
        per_d   = per_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = 5'd0;
                per_d   = 4'd0;
                grant_d = 4'd0;
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                grant_d = 4'd0;
                if (!start) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                    per_d   = 4'd0;
                end else if (en_f) begin
                    per_d = per_q + 4'd1;
                    if (per_q + 4'd1 == SYNC_LAST) begin
                        state_d = ST_ACTIVE;
                        per_d   = 4'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (en_4f) begin
                    // An empty slot clears the grant but keeps the pointer.
                    grant_d = arb_found ? arb_gnt : 4'd0;
                    if (arb_found) ptr_d = onehot_to_idx(arb_gnt);
                end
                if (!start) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // start is deliberately ignored until the drain completes.
                if (en_f) begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                    grant_d = 4'd0;
                end else if (en_4f) begin
                    grant_d = arb_found ? arb_gnt : 4'd0;
                    if (arb_found) ptr_d = onehot_to_idx(arb_gnt);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; pointer resets to 3 so lane 0 is searched first.
    always_ff @(posedge clk32f) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            per_q   <= 4'd0;
            ptr_q   <= 2'd3;
            grant_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Self-checking bench: cycle-level reference model plus directed and random stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_sched_ctrl;

    localparam int SP = 4;

    logic       clk32f;
    logic       rst;
    logic       start;
    logic [3:0] lane_valid;
    logic       en_4f, en_2f, en_f, sync_active, grant_vld;
    logic [3:0] grant;
    logic [1:0] state_o;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: mode, cycles since leaving IDLE, last granted lane, held lane (-1 = none).
    int m_state = 0;
    int m_age   = 0;
    int m_last  = 3;
    int m_lane  = -1;

    int n, n4, n2, n1, nv, ns;

    clk_sched_ctrl #(.SYNC_PERIODS(SP)) dut (
        .clk32f      (clk32f),
        .rst         (rst),
        .start       (start),
        .lane_valid  (lane_valid),
        .en_4f       (en_4f),
        .en_2f       (en_2f),
        .en_f        (en_f),
        .sync_active (sync_active),
        .grant       (grant),
        .grant_vld   (grant_vld),
        .state_o     (state_o)
    );

    initial begin
        clk32f = 1'b0;
        forever #5 clk32f = ~clk32f;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic model_pick();
        int l;
        m_lane = -1;
        for (int k = 1; k <= 4; k++) begin
            l = (m_last + k) % 4;
            if (lane_valid[l] && m_lane < 0) m_lane = l;
        end
        if (m_lane >= 0) m_last = m_lane;
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_age = 0; m_last = 3; m_lane = -1;
        end else begin
            case (m_state)
                0: if (start) begin m_state = 1; m_age = 0; end
                1: begin
                    if (!start) begin
                        m_state = 0; m_age = 0;
                    end else begin
                        if (m_age == SP * 32 - 1) m_state = 2;
                        m_age++;
                    end
                end
                2: begin
                    if (m_age % 8 == 7) model_pick();
                    if (!start) m_state = 3;
                    m_age++;
                end
                default: begin
                    if (m_age % 32 == 31) begin
                        m_state = 0; m_age = 0; m_lane = -1;
                    end else begin
                        if (m_age % 8 == 7) model_pick();
                        m_age++;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [3:0] g;
        logic       r;
        int         ph;
        r  = (m_state != 0);
        ph = m_age % 32;
        g  = (m_lane < 0) ? 4'd0 : 4'(1 << m_lane);
        return {r && (ph % 8 == 7), r && (ph % 16 == 15), r && (ph == 31),
                m_state == 1, g, |g, 2'(m_state)};
    endfunction

    function automatic logic [10:0] dut_out();
        return {en_4f, en_2f, en_f, sync_active, grant, grant_vld, state_o};
    endfunction

    // Model advances on the same edge as the DUT.
    initial forever begin
        @(posedge clk32f);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk32f);
        if (chk_en) check("model_cmp", int'(dut_out()), int'(model_out()));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic slot(input logic [3:0] lv, input logic [3:0] exp, input string nm);
        lane_valid = lv;
        for (int k = 0; k < 64 && !en_4f; k++) @(negedge clk32f);
        check({nm, "_wait"}, int'(en_4f), 1);
        @(negedge clk32f);
        check(nm, int'(grant), int'(exp));
    endtask

    task automatic wait_state(input logic [1:0] s, input string nm);
        for (int k = 0; k < 300 && state_o != s; k++) @(negedge clk32f);
        check(nm, int'(state_o), int'(s));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; lane_valid = 4'b1111;
        repeat (3) @(negedge clk32f);
        chk_en = 1'b1;
        check("reset_outputs", int'(dut_out()), 0);

        // Warm-up: 128 SYNC cycles with 16/8/4 strobes, then ACTIVE.
        rst = 1'b0; start = 1'b1;
        @(negedge clk32f);
        n = 0; n4 = 0; n2 = 0; n1 = 0;
        for (int i = 0; i < 300 && sync_active; i++) begin
            n++; n4 += int'(en_4f); n2 += int'(en_2f); n1 += int'(en_f);
            @(negedge clk32f);
        end
        check("sync_len", n, 128);
        check("sync_en4f_cnt", n4, 16);
        check("sync_en2f_cnt", n2, 8);
        check("sync_enf_cnt", n1, 4);
        check("state_after_sync", int'(state_o), 2);

        // Round-robin over all lanes, then sparse and empty request sets.
        slot(4'b1111, 4'b0001, "rr_g0");
        slot(4'b1111, 4'b0010, "rr_g1");
        slot(4'b1111, 4'b0100, "rr_g2");
        slot(4'b1111, 4'b1000, "rr_g3");
        slot(4'b1111, 4'b0001, "rr_g4");
        slot(4'b1111, 4'b0010, "rr_g5");
        slot(4'b1010, 4'b1000, "sparse_g0");
        slot(4'b1010, 4'b0010, "sparse_g1");
        slot(4'b0000, 4'b0000, "empty_g");
        check("empty_vld", int'(grant_vld), 0);
        slot(4'b0001, 4'b0001, "after_empty_g");

        // Drop start at phase 5: 26 drain cycles, start pulse ignored.
        for (int i = 0; i < 64 && !en_f; i++) @(negedge clk32f);
        check("pre_drain_enf", int'(en_f), 1);
        repeat (6) @(negedge clk32f);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk32f);
            if (state_o != 2'd3) break;
            n++;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
        end
        check("drain_len", n, 26);
        check("drain_end_state", int'(state_o), 0);
        check("drain_end_grant", int'(grant), 0);

        // Full resync, then reset in ACTIVE at phase 12 while lane 2 holds the grant.
        start = 1'b1; lane_valid = 4'b0100;
        @(negedge clk32f);
        check("resync_sync", int'(sync_active), 1);
        wait_state(2'd2, "resync_active");
        for (int i = 0; i < 64 && !en_f; i++) @(negedge clk32f);
        check("pre_rst_enf", int'(en_f), 1);
        repeat (13) @(negedge clk32f);
        check("pre_rst_grant", int'(grant), 4);
        rst = 1'b1;
        @(negedge clk32f);
        check("midrun_rst_outputs", int'(dut_out()), 0);
        rst = 1'b0; lane_valid = 4'b1111;
        @(negedge clk32f);
        check("post_rst_sync", int'(sync_active), 1);
        wait_state(2'd2, "post_rst_active");
        slot(4'b1111, 4'b0001, "post_rst_g0");

        // Abort SYNC after 40 cycles: back to IDLE, never a grant.
        rst = 1'b1; start = 1'b0;
        @(negedge clk32f);
        rst = 1'b0; start = 1'b1;
        nv = 0; ns = 0;
        repeat (40) begin
            @(negedge clk32f);
            nv += int'(grant_vld); ns += int'(sync_active);
        end
        start = 1'b0;
        @(negedge clk32f);
        check("sync_abort_state", int'(state_o), 0);
        check("sync_abort_vld", nv, 0);
        check("sync_abort_sync_cycles", ns, 40);

        // Random traffic with occasional start drops and resets.
        for (int i = 0; i < 3000; i++) begin
            lane_valid = 4'($urandom);
            if (rst) rst = 1'b0;
            else if ($urandom_range(999) == 0) rst = 1'b1;
            if (start) begin
                if ($urandom_range(299) == 0) start = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                start = 1'b1;
            end
            @(negedge clk32f);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
